hood_status_display: RTL and testbench

HOOD_STATUS_DISPLAY -- requirements
Module: hood_status_display

---
 rtl/hood_status_display_pkg.sv | 44 ++++
 rtl/hood_status_display_seg7_glyph.sv | 32 +++
 rtl/hood_status_display.sv | 158 +++++++++++++++
 tb/tb_hood_status_display.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/hood_status_display_pkg.sv
// rtl/hood_status_display_pkg.sv - shared hood state/level codes, display symbols and glyphs
// Purpose: common definitions used by the hood status display and the hood controller.
// Contents: hood state enum, one-hot level codes, 5-bit display symbols, 8-bit segment glyphs.
package hood_status_display_pkg;

  typedef enum logic [1:0] {
    ST_OFF      = 2'b00,
    ST_STANDBY  = 2'b01,
    ST_SMOKING  = 2'b10,
    ST_CLEANING = 2'b11
  } hood_state_e;

  localparam logic [3:0] LVL_OFF     = 4'b0000;
  localparam logic [3:0] LVL_STANDBY = 4'b1111;
  localparam logic [3:0] LVL_1       = 4'b0001;
  localparam logic [3:0] LVL_2       = 4'b0010;
  localparam logic [3:0] LVL_3       = 4'b0100;
  localparam logic [3:0] LVL_CLEAN   = 4'b1000;

  // Symbols 0..9 are the decimal digits themselves.
  localparam logic [4:0] SYM_L     = 5'd10;
  localparam logic [4:0] SYM_S     = 5'd11;
  localparam logic [4:0] SYM_C     = 5'd12;
  localparam logic [4:0] SYM_DASH  = 5'd13;
  localparam logic [4:0] SYM_BLANK = 5'd14;

  // Segment order {a,b,c,d,e,f,g,dp}, active-high.
  localparam logic [7:0] GLYPH_0     = 8'hFC;
  localparam logic [7:0] GLYPH_1     = 8'h60;
  localparam logic [7:0] GLYPH_2     = 8'hDA;
  localparam logic [7:0] GLYPH_3     = 8'hF2;
  localparam logic [7:0] GLYPH_4     = 8'h66;
  localparam logic [7:0] GLYPH_5     = 8'hB6;
  localparam logic [7:0] GLYPH_6     = 8'hBE;
  localparam logic [7:0] GLYPH_7     = 8'hE0;
  localparam logic [7:0] GLYPH_8     = 8'hFE;
  localparam logic [7:0] GLYPH_9     = 8'hF6;
  localparam logic [7:0] GLYPH_L     = 8'h1C;
  localparam logic [7:0] GLYPH_S     = 8'hB6;
  localparam logic [7:0] GLYPH_C     = 8'h9C;
  localparam logic [7:0] GLYPH_DASH  = 8'h02;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;

endpackage

// File: rtl/hood_status_display_seg7_glyph.sv
// rtl/hood_status_display_seg7_glyph.sv - 5-bit display symbol to 7-segment glyph lookup
// Purpose: purely combinational symbol-to-segment map.
// Ports: sym_i [4:0] symbol code (0..9 digits, L, S, C, dash, blank); seg_o [7:0] segments {a..g,dp}.
module seg7_glyph
  import hood_status_display_pkg::*;
(
  input  logic [4:0] sym_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = GLYPH_BLANK;
    case (sym_i)
      5'd0:     seg_o = GLYPH_0;
      5'd1:     seg_o = GLYPH_1;
      5'd2:     seg_o = GLYPH_2;
      5'd3:     seg_o = GLYPH_3;
      5'd4:     seg_o = GLYPH_4;
      5'd5:     seg_o = GLYPH_5;
      5'd6:     seg_o = GLYPH_6;
      5'd7:     seg_o = GLYPH_7;
      5'd8:     seg_o = GLYPH_8;
      5'd9:     seg_o = GLYPH_9;
      SYM_L:    seg_o = GLYPH_L;
      SYM_S:    seg_o = GLYPH_S;
      SYM_C:    seg_o = GLYPH_C;
      SYM_DASH: seg_o = GLYPH_DASH;
      default:  seg_o = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/hood_status_display.sv
// rtl/hood_status_display.sv - 8-digit multiplexed hood status display with status LEDs
// Purpose: scans eight digits, snapshots hood inputs once per frame, blinks low countdowns and cleaning LED.
// Ports: clk, reset_n (async, active-low); state [1:0], state_smoke_lvl [3:0], countsecond [5:0] inputs;
//        an [7:0] one-hot digit enable (an[7] leftmost), seg [7:0] segments, led [5:0] status LEDs.
module hood_status_display
  import hood_status_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] state,
  input  logic [3:0] state_smoke_lvl,
  input  logic [5:0] countsecond,
  output logic [7:0] an,
  output logic [7:0] seg,
  output logic [5:0] led
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          primed_q, primed_d;
  hood_state_e   snap_state_q, snap_state_d;
  logic [3:0]    snap_lvl_q, snap_lvl_d;
  logic [5:0]    snap_cs_q, snap_cs_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [7:0]    an_q, an_d, seg_q, seg_d;
  logic [5:0]    led_q, led_d;

  logic          term, wrap, smoking, show_secs;
  logic [2:0]    tens;
  logic [5:0]    tens10;
  logic [3:0]    units;
  logic [4:0]    sym;
  logic [7:0]    glyph;

  seg7_glyph u_glyph (
    .sym_i (sym),
    .seg_o (glyph)
  );

  always_comb begin
    term       = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = term ? '0 : scan_cnt_q + 1'b1;
    // The first terminal count after reset only starts the display at index 0,
    // so the leftmost digit is the first one lit.
    primed_d   = primed_q | term;
    idx_d      = (term && primed_q) ? idx_q + 3'd1 : idx_q;
    wrap       = term && primed_q && (idx_q == 3'd7);

    snap_state_d  = snap_state_q;
    snap_lvl_d    = snap_lvl_q;
    snap_cs_d     = snap_cs_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wrap) begin
      snap_state_d = hood_state_e'(state);
      snap_lvl_d   = state_smoke_lvl;
      snap_cs_d    = countsecond;
      // A new mode always starts with its blinking element visible.
      if ((hood_state_e'(state) != snap_state_q) || (state_smoke_lvl != snap_lvl_q)) begin
        blink_cnt_d   = '0;
        blink_phase_d = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Decimal split of 0..63 by threshold compare.
    if      (snap_cs_q >= 6'd60) begin tens = 3'd6; tens10 = 6'd60; end
    else if (snap_cs_q >= 6'd50) begin tens = 3'd5; tens10 = 6'd50; end
    else if (snap_cs_q >= 6'd40) begin tens = 3'd4; tens10 = 6'd40; end
    else if (snap_cs_q >= 6'd30) begin tens = 3'd3; tens10 = 6'd30; end
    else if (snap_cs_q >= 6'd20) begin tens = 3'd2; tens10 = 6'd20; end
    else if (snap_cs_q >= 6'd10) begin tens = 3'd1; tens10 = 6'd10; end
    else                         begin tens = 3'd0; tens10 = 6'd0;  end
    units = 4'(snap_cs_q - tens10);

    smoking   = (snap_state_q == ST_SMOKING);
    show_secs = smoking && (snap_lvl_q == LVL_3) && ((snap_cs_q > 6'd10) || blink_phase_q);

    // Index 0 drives an[7] (digit 7), index 7 drives an[0] (digit 0).
    sym = SYM_BLANK;
    case (idx_q)
      3'd0: begin
        case (snap_state_q)
          ST_STANDBY:  sym = SYM_S;
          ST_SMOKING:  sym = SYM_L;
          ST_CLEANING: sym = SYM_C;
          default:     sym = SYM_BLANK;
        endcase
      end
      3'd1: begin
        if (smoking) begin
          case (snap_lvl_q)
            LVL_1:   sym = 5'd1;
            LVL_2:   sym = 5'd2;
            LVL_3:   sym = 5'd3;
            default: sym = SYM_DASH;
          endcase
        end
      end
      3'd6:    sym = show_secs ? {2'b00, tens} : SYM_BLANK;
      3'd7:    sym = show_secs ? {1'b0, units} : SYM_BLANK;
      default: sym = SYM_BLANK;
    endcase

    an_d  = primed_d ? (8'h80 >> idx_q) : 8'h00;
    seg_d = primed_d ? glyph : 8'h00;
    led_d = {(snap_state_q == ST_CLEANING) && blink_phase_q,
             (snap_state_q != ST_OFF),
             1'b0,
             smoking ? snap_lvl_q[2:0] : 3'b000};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt_q    <= '0;
      idx_q         <= 3'd0;
      primed_q      <= 1'b0;
      snap_state_q  <= ST_OFF;
      snap_lvl_q    <= LVL_OFF;
      snap_cs_q     <= 6'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      an_q          <= 8'h00;
      seg_q         <= 8'h00;
      led_q         <= 6'h00;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      primed_q      <= primed_d;
      snap_state_q  <= snap_state_d;
      snap_lvl_q    <= snap_lvl_d;
      snap_cs_q     <= snap_cs_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      led_q         <= led_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign led = led_q;

endmodule

// File: tb/tb_hood_status_display.sv
// tb/tb_hood_status_display.sv - randomized self-checking bench for hood_status_display
module tb_hood_status_display;

  localparam int S    = 4;
  localparam int B    = 4;
  localparam int MAXN = 16384;
  localparam int MAXF = 1024;
  localparam int CYCLES = 10000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] state;
  logic [3:0] state_smoke_lvl;
  logic [5:0] countsecond;
  logic [7:0] an, seg;
  logic [5:0] led;

  always #5 clk = ~clk;

  hood_status_display #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .state           (state),
    .state_smoke_lvl (state_smoke_lvl),
    .countsecond     (countsecond),
    .an              (an),
    .seg             (seg),
    .led             (led)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
  endtask

  // Inputs seen at each rising edge since reset release, and per-frame snapshots.
  int log_st [0:MAXN-1];
  int log_lvl[0:MAXN-1];
  int log_cs [0:MAXN-1];
  int fr_st [0:MAXF-1];
  int fr_lvl[0:MAXF-1];
  int fr_cs [0:MAXF-1];
  int fr_ph [0:MAXF-1];
  int frames_known;
  int bcnt;

  logic [7:0] gl [0:13];
  initial begin
    gl[0] = 8'hFC; gl[1] = 8'h60; gl[2] = 8'hDA; gl[3] = 8'hF2; gl[4] = 8'h66;
    gl[5] = 8'hB6; gl[6] = 8'hBE; gl[7] = 8'hE0; gl[8] = 8'hFE; gl[9] = 8'hF6;
    gl[10] = 8'h1C; gl[11] = 8'hB6; gl[12] = 8'h9C; gl[13] = 8'h02;
  end

  // Frame f shows what was on the inputs at the edge that closed frame f-1;
  // the blink phase advances once per frame unless the mode changed.
  task automatic frame_upto(input int f);
    while (frames_known <= f) begin
      int fr;
      int nn;
      fr = frames_known;
      if (fr == 0) begin
        fr_st[0] = 0; fr_lvl[0] = 0; fr_cs[0] = 0; fr_ph[0] = 1; bcnt = 0;
      end else begin
        nn = S * (8 * fr + 1);
        fr_st[fr] = log_st[nn]; fr_lvl[fr] = log_lvl[nn]; fr_cs[fr] = log_cs[nn];
        if (fr_st[fr] != fr_st[fr-1] || fr_lvl[fr] != fr_lvl[fr-1]) begin
          bcnt = 0; fr_ph[fr] = 1;
        end else if (bcnt == B - 1) begin
          bcnt = 0; fr_ph[fr] = 1 - fr_ph[fr-1];
        end else begin
          bcnt++; fr_ph[fr] = fr_ph[fr-1];
        end
      end
      frames_known++;
    end
  endtask

  function automatic logic [7:0] exp_seg(input int idx, input int st, input int lvl, input int cs, input int ph);
    int digit;
    digit = 7 - idx;
    exp_seg = 8'h00;
    if (digit == 7) begin
      if (st == 1) exp_seg = gl[11];
      else if (st == 2) exp_seg = gl[10];
      else if (st == 3) exp_seg = gl[12];
    end else if (digit == 6 && st == 2) begin
      if (lvl == 1) exp_seg = gl[1];
      else if (lvl == 2) exp_seg = gl[2];
      else if (lvl == 4) exp_seg = gl[3];
      else exp_seg = gl[13];
    end else if (digit <= 1 && st == 2 && lvl == 4 && (cs > 10 || ph == 1)) begin
      exp_seg = (digit == 1) ? gl[cs / 10] : gl[cs % 10];
    end
  endfunction

  int n;
  int cur_idx;

  task automatic check_cycle();
    int s, f;
    logic [7:0] e_an, e_seg, e_led;
    cur_idx = -1;
    if (n < S) begin
      e_an = 8'h00; e_seg = 8'h00; e_led = 8'h00;
    end else begin
      s = (n - 1) / S - 1;
      if (s < 0) s = 0;
      cur_idx = s % 8;
      f = s / 8;
      frame_upto(f);
      e_an  = 8'h80 >> cur_idx;
      e_seg = exp_seg(cur_idx, fr_st[f], fr_lvl[f], fr_cs[f], fr_ph[f]);
      e_led = 8'h00;
      if (fr_st[f] == 2) e_led[2:0] = 3'(fr_lvl[f] & 7);
      if (fr_st[f] != 0) e_led[4] = 1'b1;
      if (fr_st[f] == 3 && fr_ph[f] == 1) e_led[5] = 1'b1;
    end
    check("an", an, e_an);
    check("seg", seg, e_seg);
    check("led", {2'b00, led}, e_led);
  endtask

  task automatic pick_inputs();
    int r;
    r = $urandom % 8;
    state = (r < 4) ? 2'd2 : 2'($urandom % 4);
    r = $urandom % 8;
    case (state)
      2'd0: state_smoke_lvl = (r == 0) ? 4'($urandom) : 4'b0000;
      2'd1: state_smoke_lvl = (r == 0) ? 4'($urandom) : 4'b1111;
      2'd3: state_smoke_lvl = (r == 0) ? 4'($urandom) : 4'b1000;
      default: begin
        if (r < 4) state_smoke_lvl = 4'b0100;
        else if (r == 4) state_smoke_lvl = 4'b0001;
        else if (r == 5) state_smoke_lvl = 4'b0010;
        else if (r == 6) state_smoke_lvl = 4'b0011;
        else state_smoke_lvl = 4'($urandom);
      end
    endcase
    countsecond = ($urandom % 3 == 0) ? 6'($urandom % 64) : 6'($urandom % 11);
  endtask

  initial begin
    int hold;
    int resets_done;
    reset_n = 1'b0;
    state = 2'd1; state_smoke_lvl = 4'b1111; countsecond = 6'd0;
    frames_known = 0; bcnt = 0; n = 0; resets_done = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_an", an, 8'h00);
    check("rst_seg", seg, 8'h00);
    check("rst_led", {2'b00, led}, 8'h00);
    reset_n = 1'b1;
    hold = 300;
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(posedge clk);
      n++;
      if (n >= MAXN) begin
        $display("FAIL log_overflow: got %0d expected <%0d", n, MAXN);
        n_checks++;
        break;
      end
      log_st[n] = int'(state); log_lvl[n] = int'(state_smoke_lvl); log_cs[n] = int'(countsecond);
      @(negedge clk);
      check_cycle();
      if (resets_done < 2 && cyc > 3000 * (resets_done + 1) && cur_idx == 5) begin
        reset_n = 1'b0;
        #1;
        check("async_rst_an", an, 8'h00);
        check("async_rst_seg", seg, 8'h00);
        check("async_rst_led", {2'b00, led}, 8'h00);
        @(negedge clk);
        check("hold_rst_an", an, 8'h00);
        reset_n = 1'b1;
        n = 0; frames_known = 0; bcnt = 0;
        resets_done++;
      end
      hold--;
      if (hold <= 0) begin
        pick_inputs();
        hold = $urandom_range(20, 600);
      end else if ($urandom % 50 == 0) begin
        countsecond = ($urandom % 2 == 0) ? 6'($urandom % 64) : 6'($urandom % 11);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
